// File: rtl/conv_pkg.sv
// Shared types and width helpers for the streaming 3x3 convolution engine.
package conv_pkg;

  localparam int unsigned TAPS = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SCAN,
    S_DRAIN,
    S_DONE
`ifdef CONV_CLEAR_BORDER_EN
    , S_BORDER
`endif
  } state_t;

  function automatic int unsigned addr_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned kaddr_w(input int unsigned num_ker);
    return addr_w(TAPS * num_ker);
  endfunction

  function automatic int unsigned sum_w(input int unsigned pix_w, input int unsigned coef_w);
    return pix_w + coef_w + 5;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Two row-delay lines for the 3x3 window: row_m1 is row y-1, row_m2 is row y-2 at column col.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W = 128,
  parameter int unsigned PIX_W = 3
) (
  input  logic                       clk_proc,
  input  logic                       wr_en,
  input  logic [addr_w(IMG_W)-1:0]   col,
  input  logic [PIX_W-1:0]           din,
  output logic [PIX_W-1:0]           row_m1,
  output logic [PIX_W-1:0]           row_m2
);

  logic [PIX_W-1:0] line0 [IMG_W];
  logic [PIX_W-1:0] line1 [IMG_W];

  assign row_m1 = line0[col];
  assign row_m2 = line1[col];

  // Read-before-write at the same column turns the pair into a two-row delay.
  always_ff @(posedge clk_proc) begin
    if (wr_en) begin
      line0[col] <= din;
      line1[col] <= line0[col];
    end
  end

endmodule

// File: rtl/conv_stream_engine.sv
// Streaming 3x3 convolution over a raster-scanned source frame, written to a destination RAM.
// Optional CONV_CLEAR_BORDER_EN adds a BORDER pass that zeroes the destination frame edge.
module conv_stream_engine
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W      = 128,
  parameter int unsigned IMG_H      = 128,
  parameter int unsigned PIX_W      = 3,
  parameter int unsigned COEF_W     = 5,
  parameter int unsigned NUM_KER    = 4,
  parameter int unsigned NORM_SHIFT = 0
) (
  input  logic                          clk_proc,
  input  logic                          rst,
  input  logic                          start,
  input  logic [addr_w(NUM_KER)-1:0]    ker_sel,
  output logic [kaddr_w(NUM_KER)-1:0]   ker_addr,
  input  logic signed [COEF_W-1:0]      ker_din,
  output logic [addr_w(IMG_W)-1:0]      src_x_addr,
  output logic [addr_w(IMG_H)-1:0]      src_y_addr,
  input  logic [PIX_W-1:0]              src_din,
  output logic                          we,
  output logic [addr_w(IMG_W)-1:0]      dst_x_addr,
  output logic [addr_w(IMG_H)-1:0]      dst_y_addr,
  output logic [PIX_W-1:0]              dst_dout,
  output logic                          busy,
  output logic                          done,
  output logic                          en_vga
);

  localparam int unsigned XW    = addr_w(IMG_W);
  localparam int unsigned YW    = addr_w(IMG_H);
  localparam int unsigned SW    = addr_w(NUM_KER);
  localparam int unsigned KW    = kaddr_w(NUM_KER);
  localparam int unsigned SUMW  = sum_w(PIX_W, COEF_W);
  localparam int unsigned PRODW = PIX_W + 1 + COEF_W;
  localparam logic signed [SUMW-1:0] PIX_MAX = SUMW'((2 ** PIX_W) - 1);

  state_t state, state_nxt;

  logic [SW-1:0]            sel_q;
  logic [3:0]               lcnt;
  logic [XW-1:0]            x_cnt;
  logic [YW-1:0]            y_cnt;
  logic signed [COEF_W-1:0] coef [TAPS];
  logic                     scan_last;

  assign scan_last = (state == S_SCAN) && (x_cnt == XW'(IMG_W - 1)) && (y_cnt == YW'(IMG_H - 1));

`ifdef CONV_CLEAR_BORDER_EN
  localparam int unsigned BORDER_N = 2 * IMG_W + 2 * IMG_H - 4;
  localparam int unsigned BW       = addr_w(BORDER_N);

  logic [BW-1:0]  bcnt;
  logic [31:0]    bidx;
  logic [XW-1:0]  bx;
  logic [YW-1:0]  by;
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk_proc) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  if (lcnt == 4'd9) state_nxt = S_SCAN;
      S_SCAN:  if (scan_last) state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (lcnt == 4'd2) begin
`ifdef CONV_CLEAR_BORDER_EN
          state_nxt = S_BORDER;
`else
          state_nxt = S_DONE;
`endif
        end
      end
`ifdef CONV_CLEAR_BORDER_EN
      S_BORDER: if (bcnt == BW'(BORDER_N - 1)) state_nxt = S_DONE;
`endif
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- Counters and kernel select ----------------
  always_ff @(posedge clk_proc) begin
    if (rst) begin
      sel_q <= '0;
      lcnt  <= '0;
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          lcnt <= '0;
          if (start) sel_q <= SW'(32'(ker_sel) % NUM_KER);
        end
        S_LOAD:  lcnt <= (lcnt == 4'd9) ? '0 : lcnt + 4'd1;
        S_SCAN: begin
          if (x_cnt == XW'(IMG_W - 1)) begin
            x_cnt <= '0;
            y_cnt <= (y_cnt == YW'(IMG_H - 1)) ? '0 : y_cnt + YW'(1);
          end else begin
            x_cnt <= x_cnt + XW'(1);
          end
        end
        S_DRAIN: lcnt <= (lcnt == 4'd2) ? '0 : lcnt + 4'd1;
        default: lcnt <= '0;
      endcase
    end
  end

  // Coefficient i arrives one cycle after its address, i.e. while lcnt == i+1.
  always_ff @(posedge clk_proc) begin
    if (state == S_LOAD && lcnt != 4'd0) coef[lcnt - 4'd1] <= ker_din;
  end

  always_comb begin
    ker_addr = '0;
    if (state == S_LOAD && lcnt < 4'd9) ker_addr = KW'(32'(sel_q) * TAPS + 32'(lcnt));
  end

  assign src_x_addr = x_cnt;
  assign src_y_addr = y_cnt;

  // ---------------- Pipeline: data return, window, MAC/clamp ----------------
  logic          v1, v2;
  logic [XW-1:0] x1, x2;
  logic [YW-1:0] y1, y2;
  logic [PIX_W-1:0] row_m1, row_m2;
  logic [PIX_W-1:0] win [TAPS];

  always_ff @(posedge clk_proc) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      x1 <= '0;
      y1 <= '0;
      x2 <= '0;
      y2 <= '0;
    end else begin
      v1 <= (state == S_SCAN);
      x1 <= x_cnt;
      y1 <= y_cnt;
      v2 <= v1;
      x2 <= x1;
      y2 <= y1;
    end
  end

  conv_line_buffer #(
    .IMG_W (IMG_W),
    .PIX_W (PIX_W)
  ) u_line_buffer (
    .clk_proc (clk_proc),
    .wr_en    (v1),
    .col      (x1),
    .din      (src_din),
    .row_m1   (row_m1),
    .row_m2   (row_m2)
  );

  // Window index r*3+c: row 0 is y-2 (top), column 0 is x-2 (left).
  always_ff @(posedge clk_proc) begin
    if (v1) begin
      for (int unsigned r = 0; r < 3; r++) begin
        win[r*3]     <= win[r*3 + 1];
        win[r*3 + 1] <= win[r*3 + 2];
      end
      win[2] <= row_m2;
      win[5] <= row_m1;
      win[8] <= src_din;
    end
  end

  logic signed [PRODW-1:0] prod;
  logic signed [SUMW-1:0]  acc;
  logic signed [SUMW-1:0]  shifted;
  logic [PIX_W-1:0]        clamped;

  always_comb begin
    prod = '0;
    acc  = '0;
    for (int unsigned i = 0; i < TAPS; i++) begin
      prod = PRODW'($signed({1'b0, win[i]})) * PRODW'(coef[i]);
      acc  = acc + SUMW'(prod);
    end
    shifted = acc >>> NORM_SHIFT;
    if (shifted[SUMW-1])          clamped = '0;
    else if (shifted > PIX_MAX)   clamped = '1;
    else                          clamped = shifted[PIX_W-1:0];
  end

  logic             we_q;
  logic [XW-1:0]    dx_q;
  logic [YW-1:0]    dy_q;
  logic [PIX_W-1:0] dout_q;

  always_ff @(posedge clk_proc) begin
    if (rst) begin
      we_q   <= 1'b0;
      dx_q   <= '0;
      dy_q   <= '0;
      dout_q <= '0;
    end else begin
      we_q   <= v2 && (x2 >= XW'(2)) && (y2 >= YW'(2));
      dx_q   <= x2 - XW'(1);
      dy_q   <= y2 - YW'(1);
      dout_q <= clamped;
    end
  end

  // ---------------- Border clear and output selection ----------------
`ifdef CONV_CLEAR_BORDER_EN
  always_ff @(posedge clk_proc) begin
    if (rst || state != S_BORDER) bcnt <= '0;
    else                          bcnt <= bcnt + BW'(1);
  end

  // Order: top row, bottom row, left column, right column (corners only in the rows).
  always_comb begin
    bidx = 32'(bcnt);
    bx   = '0;
    by   = '0;
    if (bidx < IMG_W) begin
      bx = XW'(bidx);
    end else if (bidx < 2 * IMG_W) begin
      bx = XW'(bidx - IMG_W);
      by = YW'(IMG_H - 1);
    end else if (bidx < 2 * IMG_W + IMG_H - 2) begin
      by = YW'(bidx - 2 * IMG_W + 1);
    end else begin
      bx = XW'(IMG_W - 1);
      by = YW'(bidx - (2 * IMG_W + IMG_H - 2) + 1);
    end
  end

  always_comb begin
    we         = we_q;
    dst_x_addr = dx_q;
    dst_y_addr = dy_q;
    dst_dout   = dout_q;
    if (state == S_BORDER) begin
      we         = 1'b1;
      dst_x_addr = bx;
      dst_y_addr = by;
      dst_dout   = '0;
    end
  end
`else
  assign we         = we_q;
  assign dst_x_addr = dx_q;
  assign dst_y_addr = dy_q;
  assign dst_dout   = dout_q;
`endif

  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);
  assign en_vga = !busy;

endmodule

// File: tb/tb_conv_stream_engine.sv
// Self-checking bench: table-driven frames with a direct-convolution scoreboard, plus reset/restart sequences.
module tb_conv_stream_engine;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int NS = 0;
`ifdef CONV_CLEAR_BORDER_EN
  localparam int NB = 2 * W + 2 * H - 4;
`else
  localparam int NB = 0;
`endif
  localparam int NINT = (W - 2) * (H - 2);
  localparam int RUN  = 10 + W * H + 3 + 1 + NB;

  logic              clk_proc = 1'b0;
  logic              rst;
  logic              start;
  logic [1:0]        ker_sel;
  logic [5:0]        ker_addr;
  logic signed [4:0] ker_din;
  logic [2:0]        src_x_addr, src_y_addr;
  logic [2:0]        src_din;
  logic              we;
  logic [2:0]        dst_x_addr, dst_y_addr;
  logic [2:0]        dst_dout;
  logic              busy, done, en_vga;

  conv_stream_engine #(
    .IMG_W      (W),
    .IMG_H      (H),
    .PIX_W      (3),
    .COEF_W     (5),
    .NUM_KER    (4),
    .NORM_SHIFT (NS)
  ) dut (
    .clk_proc   (clk_proc),
    .rst        (rst),
    .start      (start),
    .ker_sel    (ker_sel),
    .ker_addr   (ker_addr),
    .ker_din    (ker_din),
    .src_x_addr (src_x_addr),
    .src_y_addr (src_y_addr),
    .src_din    (src_din),
    .we         (we),
    .dst_x_addr (dst_x_addr),
    .dst_y_addr (dst_y_addr),
    .dst_dout   (dst_dout),
    .busy       (busy),
    .done       (done),
    .en_vga     (en_vga)
  );

  always #5 clk_proc = ~clk_proc;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int src_mem  [W*H];
  int coef_mem [36];
  int dst_mem  [W*H];

  typedef struct { int x; int y; int v; } wr_t;
  wr_t exp_q[$];
  int  n_writes;
  int  t22;
  bit  first_pending = 1'b0;

  typedef struct {
    int ksel; int pat; bit poke;
    int px0; int py0; int e0;
    int px1; int py1; int e1;
  } vec_t;
  vec_t tbl [5];

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Synchronous-read source and coefficient memories.
  always @(posedge clk_proc) begin
    cyc     <= cyc + 1;
    src_din <= 3'(src_mem[int'(src_y_addr) * W + int'(src_x_addr)]);
    ker_din <= (ker_addr < 6'd36) ? 5'(coef_mem[ker_addr]) : 5'sd0;
  end

  always @(negedge clk_proc) begin
    if (busy && src_x_addr == 3'd2 && src_y_addr == 3'd2) t22 = cyc;
    if (we) begin
      n_writes++;
      dst_mem[int'(dst_y_addr) * W + int'(dst_x_addr)] = int'(dst_dout);
      if (first_pending) begin
        first_pending = 1'b0;
        check("first_we_latency", cyc - t22, 3);
      end
      check("wr_expected", (exp_q.size() > 0) ? 1 : 0, 1);
      if (exp_q.size() > 0) begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_x", int'(dst_x_addr), e.x);
        check("wr_y", int'(dst_y_addr), e.y);
        check("wr_data", int'(dst_dout), e.v);
      end
    end
  end

  function automatic void fill_src(input int pat);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        case (pat)
          0:       src_mem[y*W + x] = (x + y) % 8;
          1:       src_mem[y*W + x] = 7;
          default: src_mem[y*W + x] = (x >= 4) ? 7 : 0;
        endcase
  endfunction

  // Direct 3x3 convolution centred at each interior pixel, in raster order.
  function automatic void build_expected(input int ksel);
    wr_t e;
    exp_q.delete();
    for (int cy = 1; cy < H - 1; cy++)
      for (int cx = 1; cx < W - 1; cx++) begin
        int s;
        s = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            s += coef_mem[ksel*9 + (dr+1)*3 + (dc+1)] * src_mem[(cy+dr)*W + (cx+dc)];
        s = s >>> NS;
        if (s < 0) s = 0;
        if (s > 7) s = 7;
        e.x = cx; e.y = cy; e.v = s;
        exp_q.push_back(e);
      end
`ifdef CONV_CLEAR_BORDER_EN
    for (int x = 0; x < W; x++) begin e.x = x;     e.y = 0;     e.v = 0; exp_q.push_back(e); end
    for (int x = 0; x < W; x++) begin e.x = x;     e.y = H - 1; e.v = 0; exp_q.push_back(e); end
    for (int y = 1; y < H - 1; y++) begin e.x = 0;     e.y = y; e.v = 0; exp_q.push_back(e); end
    for (int y = 1; y < H - 1; y++) begin e.x = W - 1; e.y = y; e.v = 0; exp_q.push_back(e); end
`endif
  endfunction

  task automatic prep_frame(input int ksel, input int pat);
    fill_src(pat);
    for (int i = 0; i < W*H; i++) dst_mem[i] = -1;
    build_expected(ksel);
    n_writes      = 0;
    first_pending = 1'b1;
  endtask

  task automatic run_frame(input int ksel, input int pat, input bit poke);
    int done_at;
    done_at = -1;
    prep_frame(ksel, pat);
    ker_sel = 2'(ksel);
    start   = 1'b1;
    @(negedge clk_proc);
    start   = 1'b0;
    ker_sel = 2'(ksel + 1);
    for (int c = 1; c <= RUN + 50; c++) begin
      if (c <= 9) check("ker_addr", int'(ker_addr), ksel*9 + c - 1);
      start = poke && (c == 40);
      if (done) begin
        done_at = c;
        break;
      end
      @(negedge clk_proc);
    end
    start = 1'b0;
    check("done_cycle", done_at, RUN);
    @(negedge clk_proc);
    check("busy_after_done", int'(busy), 0);
    check("en_vga_after_done", int'(en_vga), 1);
    check("done_single_pulse", int'(done), 0);
    check("write_count", n_writes, NINT + NB);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    for (int k = 0; k < 36; k++) coef_mem[k] = 0;
    coef_mem[0*9 + 4] = 1;
    for (int k = 0; k < 9; k++) coef_mem[1*9 + k] = 1;
    for (int k = 0; k < 9; k++) coef_mem[2*9 + k] = -1;
    coef_mem[3*9 + 1] = -1; coef_mem[3*9 + 3] = -1; coef_mem[3*9 + 4] = 4;
    coef_mem[3*9 + 5] = -1; coef_mem[3*9 + 7] = -1;
    fill_src(0);

    tbl[0] = '{ksel: 0, pat: 0, poke: 1'b0, px0: 3, py0: 4, e0: 7, px1: 1, py1: 1, e1: 2};
    tbl[1] = '{ksel: 1, pat: 1, poke: 1'b1, px0: 2, py0: 2, e0: 7, px1: 6, py1: 6, e1: 7};
    tbl[2] = '{ksel: 2, pat: 1, poke: 1'b0, px0: 3, py0: 3, e0: 0, px1: 6, py1: 1, e1: 0};
    tbl[3] = '{ksel: 3, pat: 2, poke: 1'b0, px0: 4, py0: 3, e0: 7, px1: 3, py1: 3, e1: 0};
    tbl[4] = '{ksel: 0, pat: 2, poke: 1'b1, px0: 4, py0: 2, e0: 7, px1: 3, py1: 2, e1: 0};

    rst = 1'b1; start = 1'b0; ker_sel = '0;
    repeat (3) @(negedge clk_proc);
    check("rst_we", int'(we), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_en_vga", int'(en_vga), 1);
    check("rst_ker_addr", int'(ker_addr), 0);
    check("rst_src_addr", int'({src_y_addr, src_x_addr}), 0);
    check("rst_dst_addr", int'({dst_y_addr, dst_x_addr}), 0);
    check("rst_dout", int'(dst_dout), 0);
    rst = 1'b0;
    @(negedge clk_proc);

    for (int i = 0; i < 5; i++) begin
      run_frame(tbl[i].ksel, tbl[i].pat, tbl[i].poke);
      check("probe0", dst_mem[tbl[i].py0 * W + tbl[i].px0], tbl[i].e0);
      check("probe1", dst_mem[tbl[i].py1 * W + tbl[i].px1], tbl[i].e1);
      check("border_pixel", dst_mem[0], (NB > 0) ? 0 : -1);
    end

    // Reset in the middle of SCAN, then a clean frame.
    prep_frame(1, 1);
    ker_sel = 2'd1;
    start   = 1'b1;
    @(negedge clk_proc);
    start = 1'b0;
    for (int c = 1; c < 31; c++) @(negedge clk_proc);
    check("mid_busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk_proc);
    check("midrst_we", int'(we), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_en_vga", int'(en_vga), 1);
    check("midrst_src_addr", int'({src_y_addr, src_x_addr}), 0);
    rst = 1'b0;
    exp_q.delete();
    first_pending = 1'b0;
    repeat (2) @(negedge clk_proc);
    run_frame(2, 0, 1'b0);
    check("post_rst_probe", dst_mem[3*W + 3], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_stream_engine.md
# conv_stream_engine

Parametrised streaming 3×3 image-convolution engine, the next-generation replacement for the address-per-tap processor inside the image system top. It raster-scans a source frame memory once, one pixel read per cycle. Two internal line buffers and a 3×3 window build each neighbourhood. It loads one of `NUM_KER` kernels from coefficient memory, computes a normalised, clamped result per interior pixel and writes it to the destination frame RAM. While idle it signals that the frame is stable for display.

## Interface
- `IMG_W`, 128, frame width in pixels (≥3)
- `IMG_H`, 128, frame height in pixels (≥3)
- `PIX_W`, 3, pixel width, unsigned
- `COEF_W`, 5, coefficient width, signed two's complement
- `NUM_KER`, 4, kernels in coefficient memory, 9 coefficients each, row-major
- `NORM_SHIFT`, 0, arithmetic right shift applied to the sum
- `clk_proc` in 1: the only clock; everything is on its rising edge
- `rst` in 1: reset is synchronous and active-high
- `start` in 1: one-cycle request pulse, sampled only in IDLE
- `ker_sel` in clog2(NUM_KER): kernel index, captured with `start`
- `ker_addr` out clog2(9·NUM_KER): coefficient address
- `ker_din` in COEF_W: coefficient data, valid 1 cycle after `ker_addr`
- `src_x_addr`/`src_y_addr` out clog2(IMG_W)/clog2(IMG_H): source pixel address
- `src_din` in PIX_W: source pixel, valid 1 cycle after address
- `we` out 1: destination write strobe
- `dst_x_addr`/`dst_y_addr` out clog2(IMG_W)/clog2(IMG_H): destination address
- `dst_dout` out PIX_W: destination pixel
- `busy` out 1: high from LOAD through DONE
- `done` out 1: one-cycle pulse at end of frame
- `en_vga` out 1: equals `!busy`

## Operation
- FSM states are IDLE, LOAD, SCAN, DRAIN, BORDER and DONE.
- **IDLE → LOAD:** on `start`. `ker_sel` is latched; an out-of-range value is taken modulo `NUM_KER`.
- **LOAD:** issues `ker_addr = sel·9 + i` for i = 0..8 on consecutive cycles and stores coefficient i one cycle later. Takes 10 cycles, then goes to SCAN.
- **SCAN:** issues source addresses in raster order, (0,0)…(IMG_W−1,IMG_H−1), one per cycle, with no stalls. Takes IMG_W·IMG_H cycles, then goes to DRAIN.
- **Window and line buffers:** each returned pixel shifts into the 3×3 window. The two line buffers supply rows y−1 and y−2.
- **Valid window:** when input (x,y) has x≥2 and y≥2, the window is centred at (x−1,y−1). Exactly those (IMG_W−2)·(IMG_H−2) interior outputs are written.
- **Arithmetic:**
  - Each pixel is zero-extended to PIX_W+1 signed bits and multiplied by its signed coefficient.
  - The 9 products are summed at PIX_W+COEF_W+5 bits, so nothing overflows.
  - The sum is shifted `>>> NORM_SHIFT` (arithmetic) and clamped to [0, 2^PIX_W−1].
  - Tap (0,0) is the top-left neighbour.
- **DRAIN:** 3 cycles, to flush the pipeline. Then goes to BORDER (macro set) or DONE.
- **DONE:** one cycle; `done`=1, then IDLE.
- **Boundary cases:**
  - `start` while busy is ignored.
  - `ker_sel` changes during a run have no effect.
  - Line-buffer contents are don't-care between frames; no output depends on stale rows.
- **Reset mid-operation:** on the next edge the FSM is in IDLE and every output is at its reset value. Any partially written frame stays in the RAM.

## Timing
- **Reset values:** `we`=0, `busy`=0, `done`=0, `en_vga`=1; all address and data outputs 0.
- **Source latency:** address issued at cycle t, data registered at t+1.
- **Pipeline:** window update at t+1, product/adder-tree register at t+2, shift/clamp/write register at t+3.
- **Write latency:** the write for input address (x,y) occurs at cycle t+3 with dst = (x−1,y−1). `we` is high for exactly one cycle per output.
- **Throughput:** one output per cycle across interior columns; `we` is low for the first two columns of each row.
- **Run length without the macro:** start edge + 10 + IMG_W·IMG_H + 3 + 1 cycles. `busy` falls on the cycle after `done`.

## Configuration
- **`CONV_CLEAR_BORDER_EN` defined:** the FSM enters BORDER after DRAIN.
  - It writes 0 to every border pixel, one per cycle, in order: top row left→right, bottom row left→right, left column top→bottom excluding corners, right column likewise.
  - That is 2·IMG_W + 2·IMG_H − 4 writes, then DONE.
- **Not defined:** the BORDER state and logic are absent and border pixels of the destination are never written.

## Structure
- Package `conv_pkg` holds:
  - the FSM state enum;
  - the width helpers: address widths, `KADDR_W`, `SUM_W = PIX_W+COEF_W+5`;
  - the constant `TAPS = 9`.
- Sub-module `conv_line_buffer`:
  - two IMG_W×PIX_W single-clock arrays, one read and one write per cycle, at the same column index;
  - outputs rows y−1 and y−2.
- Window, MAC tree, clamp, FSM and counters live in the top.

## Test plan
- **Identity:** IMG 8×8, kernel 0 = centre 1, others 0, NORM_SHIFT=0, src(x,y) = (x+y) mod 8 → exactly 36 writes, each dst(x,y) = src(x,y). The first `we` occurs 3 cycles after address (2,2) is issued.
- **Clamp:** box kernel all 1, constant src 7 → all writes 7 (sum 63). Kernel all −1 → all writes 0.
- **Kernel select:** `ker_sel`=2 → `ker_addr` sequence 18..26. `start` pulsed again mid-SCAN → no restart and write count unchanged.
- **Reset:** `rst` in SCAN cycle 20 → next cycle `we`=0, `busy`=0, `en_vga`=1. A following `start` completes a full, correct frame.
- **Border clear:** with `CONV_CLEAR_BORDER_EN`, 8×8 → 28 additional zero writes in the specified order, then a `done` pulse. Without the macro → 0 border writes.
- **Laplacian:** centre 4, edges −1, corners 0, src = vertical step 0|7 at x=4 → writes 7 at x=4 and 0 at x=3, others 0.
